// File: rtl/pc_gen_pkg.sv
// Shared fetch-path constants and the PC generator state type.
// Constant names mirror the legacy defines (RstEnable, ChipEnable, ...).
package pc_gen_pkg;

    localparam logic        RST_ENABLE      = 1'b1;
    localparam logic        CHIP_ENABLE     = 1'b1;
    localparam logic        CHIP_DISABLE    = 1'b0;
    localparam int          INST_ADDR_W     = 32;
    localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC0_0380;

    typedef enum logic {
        PC_STATE_OFF = 1'b0,
        PC_STATE_RUN = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one branch target that arrived while fetch was stalled.
// A newer load overwrites the held target; clear and consume both drop it.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int AW = INST_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          consume,
    input  logic          clear,
    input  logic [AW-1:0] load_target,
    output logic          valid,
    output logic [AW-1:0] target
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (clear || consume) begin
            valid  <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            target <= load_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Instruction-fetch PC generator: sequential stepping, stall hold, branch and
// exception redirect, stalled-branch buffering and misaligned-target reporting.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              AW         = INST_ADDR_W,
    parameter logic [AW-1:0]   RESET_VEC  = '0,
    parameter int              STEP       = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          branch_req,
    input  logic [AW-1:0] branch_target,
    input  logic          exc_req,
    input  logic [AW-1:0] exc_vec,
    output logic [AW-1:0] pc,
    output logic          chip_en,
    output logic          redirect_pending,
    output logic          adel,
    output logic [AW-1:0] bad_addr
);

    localparam logic [AW-1:0] ALIGN_MASK = AW'((1 << ALIGN_BITS) - 1);
    localparam logic [AW-1:0] STEP_INC   = AW'(STEP);

    pc_state_e     state;
    pc_state_e     state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [AW-1:0] bad_addr_nxt;
    logic          adel_nxt;
    logic          misaligned;
    logic          branch_ok;
    logic          buf_load;
    logic          buf_consume;
    logic          buf_clear;
    logic          pend_valid;
    logic [AW-1:0] pend_target;

    pc_redirect_buf #(
        .AW(AW)
    ) u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .consume    (buf_consume),
        .clear      (buf_clear),
        .load_target(branch_target),
        .valid      (pend_valid),
        .target     (pend_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state <= PC_STATE_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        chip_en   = CHIP_DISABLE;
        case (state)
            PC_STATE_OFF: state_nxt = PC_STATE_RUN;
            PC_STATE_RUN: chip_en   = CHIP_ENABLE;
            default:      state_nxt = PC_STATE_OFF;
        endcase
    end

    assign misaligned       = branch_req && ((branch_target & ALIGN_MASK) != '0);
    assign branch_ok        = branch_req && !misaligned;
    assign redirect_pending = pend_valid;

    // A misaligned branch is reported but otherwise behaves as no branch at all.
    always_comb begin
        pc_nxt       = pc;
        bad_addr_nxt = bad_addr;
        adel_nxt     = 1'b0;
        buf_load     = 1'b0;
        buf_consume  = 1'b0;
        buf_clear    = 1'b0;
        if (state == PC_STATE_RUN) begin
            if (exc_req) begin
                pc_nxt    = exc_vec & ~ALIGN_MASK;
                buf_clear = 1'b1;
            end else begin
                if (misaligned) begin
                    adel_nxt     = 1'b1;
                    bad_addr_nxt = branch_target;
                end
                if (branch_ok && !stall) begin
                    pc_nxt    = branch_target;
                    buf_clear = 1'b1;
                end else if (branch_ok) begin
                    buf_load = 1'b1;
                end else if (pend_valid && !stall) begin
                    pc_nxt      = pend_target;
                    buf_consume = 1'b1;
                end else if (!stall) begin
                    pc_nxt = pc + STEP_INC;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            pc       <= RESET_VEC;
            adel     <= 1'b0;
            bad_addr <= '0;
        end else begin
            pc       <= pc_nxt;
            adel     <= adel_nxt;
            bad_addr <= bad_addr_nxt;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed fetch scenarios followed by random
// stall/branch/exception/reset traffic compared against a behavioural model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_req;
    logic [31:0] branch_target;
    logic        exc_req;
    logic [31:0] exc_vec;
    logic [31:0] pc;
    logic        chip_en;
    logic        redirect_pending;
    logic        adel;
    logic [31:0] bad_addr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    bit          m_run;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_tgt;
    bit          m_adel;
    logic [31:0] m_bad;

    pc_gen #(
        .AW        (32),
        .RESET_VEC (32'h0000_0000),
        .STEP      (4),
        .ALIGN_BITS(2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_req      (branch_req),
        .branch_target   (branch_target),
        .exc_req         (exc_req),
        .exc_vec         (exc_vec),
        .pc              (pc),
        .chip_en         (chip_en),
        .redirect_pending(redirect_pending),
        .adel            (adel),
        .bad_addr        (bad_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_pc   = 32'h0;
        m_pend = 0;
        m_tgt  = 32'h0;
        m_adel = 0;
        m_bad  = 32'h0;
    endtask

    // Applies the fetch rules for one rising edge with rst low.
    task automatic model_edge();
        bit mis;
        bit good;
        if (!m_run) begin
            m_run  = 1;
            m_adel = 0;
            return;
        end
        mis    = branch_req && (branch_target % 4 != 0);
        good   = branch_req && !mis;
        m_adel = 0;
        if (exc_req) begin
            m_pc   = exc_vec - (exc_vec % 4);
            m_pend = 0;
        end else begin
            if (mis) begin
                m_adel = 1;
                m_bad  = branch_target;
            end
            if (good && !stall) begin
                m_pc   = branch_target;
                m_pend = 0;
            end else if (good) begin
                m_pend = 1;
                m_tgt  = branch_target;
            end else if (m_pend && !stall) begin
                m_pc   = m_tgt;
                m_pend = 0;
            end else if (!stall) begin
                m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pc"},   pc,                       m_pc);
        check({tag, "_ce"},   {31'd0, chip_en},          {31'd0, m_run});
        check({tag, "_pend"}, {31'd0, redirect_pending}, {31'd0, m_pend});
        check({tag, "_adel"}, {31'd0, adel},             {31'd0, m_adel});
        check({tag, "_bad"},  bad_addr,                  m_bad);
    endtask

    task automatic drive(input bit s, input bit br, input logic [31:0] tgt,
                         input bit ex, input logic [31:0] vec);
        stall         = s;
        branch_req    = br;
        branch_target = tgt;
        exc_req       = ex;
        exc_vec       = vec;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all(tag);
        drive(0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, "_hold"});
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0);
        model_reset();

        repeat (3) begin
            @(posedge clk);
            #1;
            check_all("rst");
            drive(0, 1, 32'h40, 1, 32'h80);
        end
        drive(0, 0, 32'h0, 0, 32'h0);
        rst = 1'b0;
        cycle("first");
        check("first_pc0", pc, 32'h0);
        cycle("seq4");
        check("seq_pc4", pc, 32'h4);
        cycle("seq8");
        cycle("seq12");
        check("seq_pc12", pc, 32'hC);
        cycle("seq16");

        drive(0, 1, 32'h100, 0, 32'h0);
        cycle("br100");
        check("br_pc100", pc, 32'h100);
        cycle("br104");

        drive(1, 1, 32'h200, 0, 32'h0);
        cycle("stl1");
        drive(1, 1, 32'h300, 0, 32'h0);
        cycle("stl2");
        drive(1, 0, 32'h0, 0, 32'h0);
        cycle("stl3");
        check("stl_pend", {31'd0, redirect_pending}, 32'd1);
        cycle("stl_rel");
        check("stl_pc300", pc, 32'h300);

        drive(1, 1, 32'h500, 0, 32'h0);
        cycle("pre_exc");
        drive(1, 1, 32'h400, 1, 32'hBFC0_0383);
        cycle("exc");
        check("exc_pc", pc, 32'hBFC0_0380);

        drive(0, 1, 32'h20, 0, 32'h0);
        cycle("to20");
        drive(0, 1, 32'h102, 0, 32'h0);
        cycle("mis");
        check("mis_adel", {31'd0, adel}, 32'd1);
        check("mis_bad", bad_addr, 32'h102);
        check("mis_pc", pc, 32'h24);
        cycle("mis_after");

        drive(0, 1, 32'hFFFF_FFF8, 0, 32'h0);
        cycle("toFFF8");
        cycle("wrapFFFC");
        cycle("wrap0");
        check("wrap_pc0", pc, 32'h0);
        drive(1, 1, 32'h600, 0, 32'h0);
        cycle("pend600");
        drive(1, 0, 32'h0, 0, 32'h0);
        async_reset("async");
        drive(0, 0, 32'h0, 0, 32'h0);
        cycle("post_rst");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, tgt,
                  $urandom_range(0, 15) == 0, $urandom);
            cycle("rnd");
            if ($urandom_range(0, 99) == 0) begin
                drive($urandom_range(0, 1) == 1, 0, 32'h0, 0, 32'h0);
                async_reset("rnd_rst");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
